// File: rtl/rs_issue_queue.sv
// rs_issue_queue - reservation station between dispatch and register-read.
//
// Holds up to RS_ENTRIES renamed instructions, tracks source readiness from
// writeback tag broadcasts, and each cycle moves the oldest ready entry into
// an issue register that register-read consumes with a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             squash every entry and the issue register
//   disp_valid/ready  dispatch handshake; disp_pkt is the renamed instruction
//   disp_s1_rdy/s2_rdy  source operands already produced at dispatch time
//   wb_valid/wb_preg  one destination-tag broadcast per functional unit
//   issue_valid/ready issue handshake; issue_pkt is the selected instruction

package rs_pkg;
  localparam int PW = 6;

  typedef struct packed {
    logic [31:0]   pc;
    logic [7:0]    opcode;
    logic [PW-1:0] dst_preg;
    logic [PW-1:0] src1_preg;
    logic [PW-1:0] src2_preg;
  } disp_packet_t;
endpackage

module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int RS_ENTRIES = 4,
  parameter int NUM_FUS    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  disp_packet_t                disp_pkt,
  input  logic                        disp_s1_rdy,
  input  logic                        disp_s2_rdy,
  input  logic [NUM_FUS-1:0]          wb_valid,
  input  logic [NUM_FUS-1:0][PW-1:0]  wb_preg,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output disp_packet_t                issue_pkt
);

  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  logic [RS_ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
  logic [RS_ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
  disp_packet_t          pkt_q [RS_ENTRIES];
  disp_packet_t          pkt_d [RS_ENTRIES];
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [RS_ENTRIES-1:0] age_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] age_d [RS_ENTRIES];
  logic                  issue_valid_q, issue_valid_d;
  disp_packet_t          issue_pkt_q, issue_pkt_d;

  logic [RS_ENTRIES-1:0] wake1, wake2, cand, sel_oh, alloc_oh;
  logic                  disp_wake1, disp_wake2;
  logic                  advance, disp_fire, any_cand;
  disp_packet_t          sel_pkt;

  // Per-entry wakeup match and oldest-candidate detection
  for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
    logic w1, w2, older_all;

    always_comb begin
      w1 = 1'b0;
      w2 = 1'b0;
      for (int k = 0; k < NUM_FUS; k++) begin
        if (wb_valid[k] && wb_preg[k] == pkt_q[gi].src1_preg) w1 = 1'b1;
        if (wb_valid[k] && wb_preg[k] == pkt_q[gi].src2_preg) w2 = 1'b1;
      end
    end

    assign wake1[gi] = w1;
    assign wake2[gi] = w2;
    assign cand[gi]  = valid_q[gi] & s1_rdy_q[gi] & s2_rdy_q[gi];

    // Winner must be older than every other candidate; at most one can be.
    always_comb begin
      older_all = 1'b1;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if (j != gi && cand[j] && !age_q[gi][j]) older_all = 1'b0;
      end
    end

    assign sel_oh[gi] = cand[gi] & older_all;
  end

  // Same-cycle broadcast match for the instruction being dispatched
  always_comb begin
    disp_wake1 = 1'b0;
    disp_wake2 = 1'b0;
    for (int k = 0; k < NUM_FUS; k++) begin
      if (wb_valid[k] && wb_preg[k] == disp_pkt.src1_preg) disp_wake1 = 1'b1;
      if (wb_valid[k] && wb_preg[k] == disp_pkt.src2_preg) disp_wake2 = 1'b1;
    end
  end

  // Lowest-index free entry (only entries free at the start of the cycle)
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!valid_q[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (sel_oh[i]) sel_pkt = pkt_q[i];
    end
  end

  assign any_cand   = |cand;
  assign disp_ready = ~&valid_q;
  assign advance    = !issue_valid_q || issue_ready;
  assign disp_fire  = disp_valid && disp_ready && !flush;

  always_comb begin
    valid_d       = valid_q;
    s1_rdy_d      = s1_rdy_q | wake1;
    s2_rdy_d      = s2_rdy_q | wake2;
    pkt_d         = pkt_q;
    age_d         = age_q;
    issue_valid_d = issue_valid_q;
    issue_pkt_d   = issue_pkt_q;

    if (advance) begin
      issue_valid_d = any_cand;
      issue_pkt_d   = sel_pkt;
      valid_d       = valid_q & ~sel_oh;
    end

    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (disp_fire && alloc_oh[i]) begin
        valid_d[i]  = 1'b1;
        pkt_d[i]    = disp_pkt;
        s1_rdy_d[i] = disp_s1_rdy | disp_wake1;
        s2_rdy_d[i] = disp_s2_rdy | disp_wake2;
        age_d[i]    = '0;
        // Every currently valid entry (including one issuing now) is older
        for (int j = 0; j < RS_ENTRIES; j++) begin
          age_d[j][i] = valid_q[j];
        end
      end
    end

    if (flush) begin
      valid_d       = '0;
      issue_valid_d = 1'b0;
      for (int i = 0; i < RS_ENTRIES; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      s1_rdy_q      <= '0;
      s2_rdy_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_pkt_q   <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      valid_q       <= valid_d;
      s1_rdy_q      <= s1_rdy_d;
      s2_rdy_q      <= s2_rdy_d;
      issue_valid_q <= issue_valid_d;
      issue_pkt_q   <= issue_pkt_d;
      for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end

  // Payload storage needs no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_ENTRIES; i++) pkt_q[i] <= pkt_d[i];
  end

  assign issue_valid = issue_valid_q;
  assign issue_pkt   = issue_pkt_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue - scoreboard bench for rs_issue_queue.
// Expected issue PCs are queued when an instruction is driven ready (or woken)
// and popped when the issue handshake completes.

module tb_rs_issue_queue;
  import rs_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 disp_valid;
  logic                 disp_ready;
  disp_packet_t         disp_pkt;
  logic                 disp_s1_rdy;
  logic                 disp_s2_rdy;
  logic [3:0]           wb_valid;
  logic [3:0][PW-1:0]   wb_preg;
  logic                 issue_valid;
  logic                 issue_ready;
  disp_packet_t         issue_pkt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q [$];

  rs_issue_queue #(.RS_ENTRIES(4), .NUM_FUS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_pkt    (disp_pkt),
    .disp_s1_rdy (disp_s1_rdy),
    .disp_s2_rdy (disp_s2_rdy),
    .wb_valid    (wb_valid),
    .wb_preg     (wb_preg),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_pkt   (issue_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [PW-1:0] s1,
                      input logic [PW-1:0] s2, input logic r1, input logic r2);
    disp_valid         = 1'b1;
    disp_pkt           = '0;
    disp_pkt.pc        = pc;
    disp_pkt.dst_preg  = 6'd40;
    disp_pkt.src1_preg = s1;
    disp_pkt.src2_preg = s2;
    disp_s1_rdy        = r1;
    disp_s2_rdy        = r2;
    $display("dispatch pc=%h src1=%0d(%0b) src2=%0d(%0b) disp_ready=%0b",
             pc, s1, r1, s2, r2, disp_ready);
    tick();
    disp_valid  = 1'b0;
    disp_s1_rdy = 1'b0;
    disp_s2_rdy = 1'b0;
  endtask

  // Scoreboard: every completed issue handshake must match the queue head
  always @(negedge clk) begin
    if (!rst && !flush && issue_valid && issue_ready) begin
      if (sb_q.size() == 0) begin
        $display("issue pc=%h with empty scoreboard", issue_pkt.pc);
        check("sb_unexpected_issue", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb_q.pop_front();
        $display("issue pc=%h expected %h", issue_pkt.pc, exp_pc);
        check("sb_issue_pc", issue_pkt.pc, exp_pc);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_pkt = '0;
    disp_s1_rdy = 1'b0; disp_s2_rdy = 1'b0; wb_valid = '0; wb_preg = '0;
    issue_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_pkt_pc", issue_pkt.pc, 32'd0);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);

    // 1: ready dispatch issues two cycles later
    sb_q.push_back(32'h100);
    disp(32'h100, 6'd1, 6'd2, 1'b1, 1'b1);
    check("t1_n1_issue_valid", 32'(issue_valid), 32'd0);
    tick();
    check("t1_n2_issue_valid", 32'(issue_valid), 32'd1);
    check("t1_n2_pc", issue_pkt.pc, 32'h100);
    tick();
    check("t1_drained", 32'(issue_valid), 32'd0);
    check("t1_disp_ready", 32'(disp_ready), 32'd1);

    // 2: not-ready A is bypassed by ready B, then woken via port 2
    disp(32'h200, 6'd5, 6'd6, 1'b0, 1'b1);
    sb_q.push_back(32'h204);
    disp(32'h204, 6'd7, 6'd8, 1'b1, 1'b1);
    tick();
    check("t2_b_valid", 32'(issue_valid), 32'd1);
    check("t2_b_pc", issue_pkt.pc, 32'h204);
    tick();
    check("t2_a_waiting", 32'(issue_valid), 32'd0);
    wb_valid   = 4'b0100;
    wb_preg[2] = 6'd5;
    sb_q.push_back(32'h200);
    $display("broadcast preg=5 on port 2");
    tick();
    wb_valid = '0;
    check("t2_a_n1", 32'(issue_valid), 32'd0);
    tick();
    check("t2_a_n2", 32'(issue_valid), 32'd1);
    check("t2_a_pc", issue_pkt.pc, 32'h200);
    tick();
    check("t2_drained", 32'(issue_valid), 32'd0);

    // 3: fill, refuse extra dispatch, wake all, FIFO order out
    for (int i = 0; i < 4; i++)
      disp(32'h300 + 32'(4 * i), 6'(10 + i), 6'd20, 1'b0, 1'b1);
    check("t3_full", 32'(disp_ready), 32'd0);
    disp(32'h3f0, 6'd1, 6'd1, 1'b1, 1'b1);
    check("t3_full_after_try", 32'(disp_ready), 32'd0);
    wb_valid = 4'hf;
    for (int k = 0; k < 4; k++) begin
      wb_preg[k] = 6'(10 + k);
      sb_q.push_back(32'h300 + 32'(4 * k));
    end
    $display("broadcast preg=10..13 on ports 0..3");
    tick();
    wb_valid = '0;
    check("t3_n1_full", 32'(disp_ready), 32'd0);
    check("t3_n1_issue_valid", 32'(issue_valid), 32'd0);
    tick();
    check("t3_n2_issue_valid", 32'(issue_valid), 32'd1);
    check("t3_n2_disp_ready", 32'(disp_ready), 32'd1);
    check("t3_n2_pc", issue_pkt.pc, 32'h300);
    repeat (4) tick();
    check("t3_drained", 32'(issue_valid), 32'd0);

    // 4: stall holds the issue register and frees nothing
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(32'h400 + 32'(4 * i));
      disp(32'h400 + 32'(4 * i), 6'd1, 6'd2, 1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_valid", 32'(issue_valid), 32'd1);
      check("t4_stall_pc", issue_pkt.pc, 32'h400);
      tick();
    end
    for (int i = 3; i < 5; i++) begin
      sb_q.push_back(32'h400 + 32'(4 * i));
      disp(32'h400 + 32'(4 * i), 6'd1, 6'd2, 1'b1, 1'b1);
    end
    check("t4_full_while_stalled", 32'(disp_ready), 32'd0);
    check("t4_pc_still", issue_pkt.pc, 32'h400);
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_stream_valid", 32'(issue_valid), 32'd1);
      tick();
    end
    check("t4_drained", 32'(issue_valid), 32'd0);

    // 5: same-cycle broadcast wakes src2 at dispatch
    wb_valid   = 4'b0001;
    wb_preg[0] = 6'd33;
    sb_q.push_back(32'h500);
    disp(32'h500, 6'd1, 6'd33, 1'b1, 1'b0);
    wb_valid = '0;
    check("t5_n1", 32'(issue_valid), 32'd0);
    tick();
    check("t5_n2_valid", 32'(issue_valid), 32'd1);
    check("t5_n2_pc", issue_pkt.pc, 32'h500);
    tick();
    check("t5_drained", 32'(issue_valid), 32'd0);

    // 6: flush with three entries and a loaded issue register
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      disp(32'h600 + 32'(4 * i), 6'd1, 6'd2, 1'b1, 1'b1);
    check("t6_pre_valid", 32'(issue_valid), 32'd1);
    check("t6_pre_disp_ready", 32'(disp_ready), 32'd1);
    flush = 1'b1;
    disp(32'h6ff, 6'd1, 6'd2, 1'b1, 1'b1);
    flush = 1'b0;
    $display("flush applied");
    check("t6_post_valid", 32'(issue_valid), 32'd0);
    check("t6_post_disp_ready", 32'(disp_ready), 32'd1);
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_nothing_issues", 32'(issue_valid), 32'd0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
